adder_rca_pipe: RTL
===================

Name: adder_rca_pipe

Overview:
- Pipelined, parametrised ripple-carry adder/subtractor with a valid/ready stream interface on both sides.
- Operands are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers the carry and the partial sum.
- Used in datapaths whose full-width carry chain cannot close timing in one cycle. Throughput is one operation per clock when the sink does not stall.

Parameters:
- N, 16, operand/sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; chunk width W = N/STAGES. STAGES=1 is legal and gives a registered full-width adder.

Ports:
- clk  input  1  single clock, rising edge.
- rstb  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- a  input  N  operand A, unsigned or two's complement.
- b  input  N  operand B.
- ci  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = a+b+ci; 1 = a-b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- s  output  N  sum/difference.
- co  output  1  carry-out of the MSB (for sub, 1 means no borrow).

Behaviour:
- Reset: clk is the single clock; rstb is asynchronous and active-low.
  - While rstb=0: all stage valid flags are 0, out_valid=0, s=0, co=0.
  - Data registers reset to 0.
  - Reset asserted mid-operation discards every in-flight operation; nothing is emitted afterwards.
- Transfers:
  - An input transfer occurs when in_valid and in_ready are both 1.
  - An output transfer occurs when out_valid and out_ready are both 1.
- Preprocessing at the input:
  - b_eff = sub ? ~b : b.
  - c_in = sub ? 1 : ci.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of a and b_eff (bits k*W .. k*W+W-1) plus the carry registered by stage k-1. Stage 0 uses c_in.
  - Registers the W-bit chunk sum, the carry-out, all lower sum chunks already computed, and all upper operand chunks not yet added.
  - Registers only the chunks still needed; the implementation carries no full-width a/b copies in the final stage.
- The last stage register drives s, co and out_valid directly; outputs are registered with no combinational path from a/b.
- Latency: STAGES cycles from input transfer to out_valid, given no stall.
- Flow control (per-stage enables):
  - en[STAGES-1] = !out_valid || out_ready.
  - en[k] = !v[k] || en[k+1].
  - in_ready = en[0].
  - The ready path is combinational through all stages; this is accepted.
- Stage advance: when en[k]=1, stage k loads the previous stage's data and valid. Stage 0 loads v = in_valid & in_ready.
- Bubbles collapse: an empty stage accepts new data even if downstream is stalled.
- Stall: when out_ready=0 and out_valid=1, s and co hold stable. Upstream stages keep filling until every stage is valid, then in_ready drops to 0.
- Ordering is preserved; results emerge exactly in input order, never duplicated or dropped.
- Simultaneous out transfer and a full pipe: in_ready=1 in the same cycle, so a full pipe still sustains one operation per cycle.
- Wrap-around: s = (a + b_eff + c_in) mod 2^N; co = bit N of that sum.
- in_valid may deassert at any time; the block never samples a/b/ci/sub without in_valid.

Optional Feature:
- Macro: ADDER_RCA_PIPE_OVF_EN.
- When defined:
  - Adds an output port ovf (1 bit), the signed overflow = carry into the MSB XOR carry out of the MSB.
  - ovf is registered and aligned with s, resets to 0, and holds during a stall.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package adder_pkg:
  - function for chunk width N/STAGES;
  - a compile-time check that N % STAGES == 0;
  - stage record typedef {valid, carry, sum_lo, a_hi, b_hi}.
- One natural sub-module: adder_rca_pipe_stage.
  - Contains the W-bit ripple chunk plus its enable/valid register.
  - Instantiated STAGES times in a generate loop.

Test Plan:
- Basic add, N=16, STAGES=4, out_ready=1: a=0x1234, b=0x0FFF, ci=1, sub=0 -> 4 cycles later out_valid=1, s=0x2234, co=0.
- Carry across all chunks: a=0xFFFF, b=0x0000, ci=1 -> s=0x0000, co=1. With OVF_EN: ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1, ci=1 (ignored) -> s=0xFFFE, co=0. Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, co=1, ovf=1.
- Back-to-back stream: 100 random ops at in_valid=1 with out_ready=1 -> in_ready stays 1 and one result per cycle after a 4-cycle fill. Results match a reference model in order.
- Backpressure:
  - Drive out_ready=0 while streaming -> in_ready falls after 4 accepted ops; s/co held stable.
  - Release out_ready -> all results emerge in order, none lost or duplicated.
  - Random out_ready/in_valid toggling over 1000 ops gives a scoreboard match.
- Reset mid-flight: pulse rstb low with 3 ops in flight -> out_valid=0 immediately (async), s=0, and no stale results after release.

Source files
------------

// File: rtl/adder_pkg.sv
// Purpose: shared helpers and per-stage control record for the pipelined ripple-carry adder.
// Latency: none (types and constant functions only).
// Backpressure: none; see adder_rca_pipe for the stream handshake.
package adder_pkg;

  // Control half of a stage record. The data half is one packed vector per stage,
  // laid out as {b_hi, a_hi, sum_lo}: upper operand chunks not yet added sit above
  // the sum chunks already produced, so no stage carries full-width a/b copies.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  // Width of the chunk rippled by each stage.
  function automatic int chunk_w(input int n, input int stages);
    return n / stages;
  endfunction

  // True when the operand width splits evenly into the requested stage count.
  function automatic bit chunk_ok(input int n, input int stages);
    return (stages > 0) && (n >= stages) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_rca_pipe_stage.sv
// Purpose: one pipeline stage - ripples chunk K of a + b_eff + carry and registers it with valid/carry.
// Latency: 1 cycle; loads only when en=1, data loads only for a valid bundle (ovf via ADDER_RCA_PIPE_OVF_EN).
// Backpressure: holds its contents while en=0; en is computed by the parent from downstream state.
module adder_rca_pipe_stage
  import adder_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4,
  parameter int K      = 0,
  localparam int W     = chunk_w(N, STAGES),
  localparam int DIN   = 2*N - K*W,
  localparam int DOUT  = 2*N - (K+1)*W
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            en,
  input  logic            vin,
  input  logic            cin,
  input  logic [DIN-1:0]  din,
  output logic            v,
  output logic            c,
  output logic [DOUT-1:0] dout
`ifdef ADDER_RCA_PIPE_OVF_EN
  ,
  input  logic            ovf_in,
  output logic            ovf
`endif
);

  localparam bit LAST = (K == STAGES-1);

  logic [W-1:0]    a_ck;
  logic [W-1:0]    b_ck;
  logic [W-1:0]    s_ck;
  logic            c_ck;
  logic [N-1:0]    mid_nxt;
  logic [DOUT-1:0] dout_nxt;
  stage_ctl_t      ctl_q;

  // Chunk K of a sits in place in the low N bits; the lowest remaining b chunk sits at bit N.
  assign a_ck = din[K*W +: W];
  assign b_ck = din[N +: W];
  assign {c_ck, s_ck} = {1'b0, a_ck} + {1'b0, b_ck} + {{W{1'b0}}, cin};

  // Replace the consumed a chunk with its sum so the low field grows as sum_lo.
  always_comb begin
    mid_nxt           = din[N-1:0];
    mid_nxt[K*W +: W] = s_ck;
  end

  if (LAST) begin : g_last
    assign dout_nxt = mid_nxt;
  end else begin : g_pass
    assign dout_nxt = {din[DIN-1:N+W], mid_nxt};
  end

  // Valid advances on every enable so bubbles collapse; carry/data load only for a real bundle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ctl_q <= '0;
      dout  <= '0;
    end else if (en) begin
      ctl_q.valid <= vin;
      if (vin) begin
        ctl_q.carry <= c_ck;
        dout        <= dout_nxt;
      end
    end
  end

  assign v = ctl_q.valid;
  assign c = ctl_q.carry;

`ifdef ADDER_RCA_PIPE_OVF_EN
  logic ovf_nxt;

  // Carry into the MSB equals a^b^s at that bit; only the top chunk owns the sign bit.
  assign ovf_nxt = ovf_in | (LAST & (a_ck[W-1] ^ b_ck[W-1] ^ s_ck[W-1] ^ c_ck));

  // Overflow flag travels with the data it describes.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ovf <= 1'b0;
    end else if (en && vin) begin
      ovf <= ovf_nxt;
    end
  end
`endif

endmodule

// File: rtl/adder_rca_pipe.sv
// Purpose: pipelined ripple-carry adder/subtractor, STAGES chunks of N/STAGES bits; optional ovf via ADDER_RCA_PIPE_OVF_EN.
// Latency: STAGES cycles from input transfer to out_valid; one op per clock when unstalled.
// Backpressure: per-stage enables, bubbles collapse; in_ready drops only when every stage holds a result.
module adder_rca_pipe
  import adder_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         co
`ifdef ADDER_RCA_PIPE_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W = chunk_w(N, STAGES);

  if (!chunk_ok(N, STAGES)) begin : g_bad_cfg
    $error("adder_rca_pipe: N must be a positive multiple of STAGES");
  end

  logic [N-1:0] b_eff;
  logic         c_in;

  // Subtraction is a + ~b + 1; ci is ignored in that mode.
  assign b_eff = sub ? ~b : b;
  assign c_in  = sub | ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int DIN  = 2*N - k*W;
    localparam int DOUT = 2*N - (k+1)*W;

    logic [DIN-1:0]  din;
    logic            vin;
    logic            cin;
    logic            en;
    logic            v;
    logic            c;
    logic [DOUT-1:0] dout;
`ifdef ADDER_RCA_PIPE_OVF_EN
    logic            ovf_in;
    logic            ovf_q;
`endif

    if (k == 0) begin : g_head
      assign din = {b_eff, a};
      assign vin = in_valid;
      assign cin = c_in;
`ifdef ADDER_RCA_PIPE_OVF_EN
      assign ovf_in = 1'b0;
`endif
    end else begin : g_body
      assign din = g_st[k-1].dout;
      assign vin = g_st[k-1].v;
      assign cin = g_st[k-1].c;
`ifdef ADDER_RCA_PIPE_OVF_EN
      assign ovf_in = g_st[k-1].ovf_q;
`endif
    end

    // A stage may load when it is empty or its successor is moving.
    if (k == STAGES-1) begin : g_tail
      assign en = !v || out_ready;
    end else begin : g_fwd
      assign en = !v || g_st[k+1].en;
    end

    adder_rca_pipe_stage #(
      .N      (N),
      .STAGES (STAGES),
      .K      (k)
    ) u_stage (
      .clk    (clk),
      .rstb   (rstb),
      .en     (en),
      .vin    (vin),
      .cin    (cin),
      .din    (din),
      .v      (v),
      .c      (c),
      .dout   (dout)
`ifdef ADDER_RCA_PIPE_OVF_EN
      ,
      .ovf_in (ovf_in),
      .ovf    (ovf_q)
`endif
    );
  end

  assign in_ready  = g_st[0].en;
  assign out_valid = g_st[STAGES-1].v;
  assign s         = g_st[STAGES-1].dout;
  assign co        = g_st[STAGES-1].c;
`ifdef ADDER_RCA_PIPE_OVF_EN
  assign ovf       = g_st[STAGES-1].ovf_q;
`endif

endmodule
